// File: rtl/fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// fetch_predict_unit
//   Fetch-side PC sequencer for the 5-stage RV32I pipeline. It owns the
//   F-stage PC and the F/D PC/valid register, and it holds a 2-bit branch
//   history table (BHT) that is read in D and trained from E.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   stall           D-stage data hazard: hold F and D
//   cannot_predict  D target not computable this cycle: fetch sequentially
//   d_is_branch     D holds a conditional branch
//   d_is_jump       D holds jal/jalr
//   d_target        D-computed target (bits [1:0] ignored)
//   e_valid/e_pc/e_taken   E-stage branch resolution, trains the BHT
//   e_mispredict/e_correct_pc   E-stage redirect (bits [1:0] ignored)
//   pcF             instruction memory fetch address
//   pcD, validD     PC and valid flag of the instruction in D
//   predict_takenD  D-stage prediction, carried down to E
// ---------------------------------------------------------------------------
module fetch_predict_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        cannot_predict,
  input  logic        d_is_branch,
  input  logic        d_is_jump,
  input  logic [31:0] d_target,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_taken,
  input  logic        e_mispredict,
  input  logic [31:0] e_correct_pc,
  output logic [31:0] pcF,
  output logic [31:0] pcD,
  output logic        validD,
  output logic        predict_takenD
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;

  logic [1:0]          bht_q [ENTRIES];
  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic                bht_taken;

  // Address bits that never reach the table or the word-aligned PC.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{e_pc[31:IDX_BITS+2], e_pc[1:0],
                              d_target[1:0], e_correct_pc[1:0]};

  assign rd_idx    = pc_d_q[IDX_BITS+1:2];
  assign wr_idx    = e_pc[IDX_BITS+1:2];
  // Read is the registered value: a same-cycle E update is not bypassed.
  assign bht_taken = bht_q[rd_idx][1];

  assign predict_takenD = valid_d_q & ~cannot_predict &
                          (d_is_jump | (d_is_branch & bht_taken));

  always_comb begin
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    if (e_mispredict) begin
      // D holds a wrong-path instruction, so this wins over stall.
      pc_f_d    = {e_correct_pc[31:2], 2'b00};
      valid_d_d = 1'b0;
    end else if (stall) begin
      pc_f_d    = pc_f_q;
    end else if (predict_takenD) begin
      // The fall-through fetch moving into D is squashed.
      pc_f_d    = {d_target[31:2], 2'b00};
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b0;
    end else begin
      pc_f_d    = pc_f_q + 32'd4;
      pc_d_d    = pc_f_q;
      valid_d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q    <= RESET_PC;
      pc_d_q    <= 32'h0000_0000;
      valid_d_q <= 1'b0;
    end else begin
      pc_f_q    <= pc_f_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  // Saturating 2-bit counters, reset to weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (e_valid) begin
      if (e_taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_q[wr_idx] <= bht_q[wr_idx] + 2'b01;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_q[wr_idx] <= bht_q[wr_idx] - 2'b01;
      end
    end
  end

  assign pcF    = pc_f_q;
  assign pcD    = pc_d_q;
  assign validD = valid_d_q;

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        cannot_predict = 1'b0;
  logic        d_is_branch = 1'b0;
  logic        d_is_jump = 1'b0;
  logic [31:0] d_target = '0;
  logic        e_valid = 1'b0;
  logic [31:0] e_pc = '0;
  logic        e_taken = 1'b0;
  logic        e_mispredict = 1'b0;
  logic [31:0] e_correct_pc = '0;
  logic [31:0] pcF;
  logic [31:0] pcD;
  logic        validD;
  logic        predict_takenD;

  always #5 clk = ~clk;

  fetch_predict_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .cannot_predict (cannot_predict),
    .d_is_branch    (d_is_branch),
    .d_is_jump      (d_is_jump),
    .d_target       (d_target),
    .e_valid        (e_valid),
    .e_pc           (e_pc),
    .e_taken        (e_taken),
    .e_mispredict   (e_mispredict),
    .e_correct_pc   (e_correct_pc),
    .pcF            (pcF),
    .pcD            (pcD),
    .validD         (validD),
    .predict_takenD (predict_takenD)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural reference: plain PC arithmetic and an integer counter table.
  logic [31:0] m_pcf;
  logic [31:0] m_pcd;
  bit          m_vd;
  bit          m_pcd_known;
  int          m_bht [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int bht_index(input logic [31:0] addr);
    return int'((addr / 32'd4) % 32'd64);
  endfunction

  function automatic bit m_pred();
    bit taken_guess;
    taken_guess = (m_bht[bht_index(m_pcd)] >= 2);
    return m_vd && !cannot_predict && (d_is_jump || (d_is_branch && taken_guess));
  endfunction

  task automatic model_reset();
    m_pcf       = 32'h0000_0000;
    m_pcd       = 32'h0000_0000;
    m_vd        = 1'b0;
    m_pcd_known = 1'b1;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic model_step();
    bit p;
    int k;
    p = m_pred();
    if (e_valid) begin
      k = bht_index(e_pc);
      if (e_taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
      else         m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
    end
    if (e_mispredict) begin
      m_pcf       = e_correct_pc & 32'hFFFF_FFFC;
      m_vd        = 1'b0;
      m_pcd_known = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (p) begin
      m_pcd       = m_pcf;
      m_pcf       = d_target & 32'hFFFF_FFFC;
      m_vd        = 1'b0;
      m_pcd_known = 1'b1;
    end else begin
      m_pcd       = m_pcf;
      m_pcf       = m_pcf + 32'd4;
      m_vd        = 1'b1;
      m_pcd_known = 1'b1;
    end
  endtask

  task automatic check_model();
    #1;
    chk("model_pcF", pcF, m_pcf);
    chk("model_validD", {31'b0, validD}, {31'b0, m_vd});
    chk("model_predict", {31'b0, predict_takenD}, {31'b0, m_pred()});
    if (m_pcd_known) chk("model_pcD", pcD, m_pcd);
  endtask

  // Inputs are set at edge+1; compared at edge+2; model advances at the edge.
  task automatic cyc();
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic zero_inputs();
    stall = 0; cannot_predict = 0; d_is_branch = 0; d_is_jump = 0;
    d_target = '0; e_valid = 0; e_pc = '0; e_taken = 0;
    e_mispredict = 0; e_correct_pc = '0;
  endtask

  task automatic redirect(input logic [31:0] addr);
    zero_inputs();
    e_mispredict = 1; e_correct_pc = addr;
    cyc();
    zero_inputs();
  endtask

  task automatic train(input logic [31:0] pc, input bit taken);
    zero_inputs();
    e_valid = 1; e_pc = pc; e_taken = taken;
    cyc();
    zero_inputs();
  endtask

  initial begin
    zero_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pcF", pcF, 32'h0);
    chk("reset_validD", {31'b0, validD}, 32'd0);
    chk("reset_pcD", pcD, 32'h0);
    chk("reset_predict", {31'b0, predict_takenD}, 32'd0);
    rst_n = 1;

    // Free-running sequential fetch.
    cyc();
    chk("seq1_pcF", pcF, 32'h4);
    chk("seq1_validD", {31'b0, validD}, 32'd1);
    chk("seq1_pcD", pcD, 32'h0);
    cyc();
    chk("seq2_pcF", pcF, 32'h8);
    chk("seq2_pcD", pcD, 32'h4);
    cyc();
    chk("seq3_pcF", pcF, 32'hC);
    chk("seq3_pcD", pcD, 32'h8);

    // Jump at pcD=0x8.
    d_is_jump = 1; d_target = 32'h100;
    #1;
    chk("jump_predict", {31'b0, predict_takenD}, 32'd1);
    cyc();
    chk("jump_pcF", pcF, 32'h100);
    chk("jump_bubble", {31'b0, validD}, 32'd0);
    zero_inputs();
    cyc();
    chk("jump_pcD", pcD, 32'h100);
    chk("jump_validD", {31'b0, validD}, 32'd1);

    // Branch at 0x20 with an untrained counter; same-cycle update not bypassed.
    redirect(32'h20);
    cyc();
    chk("br_pcD", pcD, 32'h20);
    d_is_branch = 1; d_target = 32'h40;
    e_valid = 1; e_pc = 32'h20; e_taken = 1;
    #1;
    chk("br_untrained_predict", {31'b0, predict_takenD}, 32'd0);
    cyc();
    chk("br_nottaken_pcF", pcF, 32'h28);
    train(32'h20, 1);
    train(32'h20, 1);

    // Trained to strongly taken; target bit 0 must be dropped.
    redirect(32'h20);
    cyc();
    d_is_branch = 1; d_target = 32'h41;
    e_valid = 1; e_pc = 32'h20; e_taken = 1;
    #1;
    chk("br_trained_predict", {31'b0, predict_takenD}, 32'd1);
    cyc();
    chk("br_taken_pcF", pcF, 32'h40);
    chk("br_taken_bubble", {31'b0, validD}, 32'd0);
    // One not-taken after saturation leaves it weakly taken.
    train(32'h20, 0);
    redirect(32'h20);
    cyc();
    d_is_branch = 1; d_target = 32'h40;
    #1;
    chk("br_saturated_predict", {31'b0, predict_takenD}, 32'd1);
    zero_inputs();

    // Stall holds F and D; mispredict overrides stall.
    redirect(32'h10);
    cyc();
    chk("stall_pre_pcF", pcF, 32'h14);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_pcF", pcF, 32'h14);
      chk("stall_pcD", pcD, 32'h10);
      chk("stall_validD", {31'b0, validD}, 32'd1);
    end
    e_mispredict = 1; e_correct_pc = 32'h202;
    cyc();
    chk("stall_misp_pcF", pcF, 32'h200);
    chk("stall_misp_validD", {31'b0, validD}, 32'd0);
    zero_inputs();

    // cannot_predict forces sequential fetch.
    redirect(32'h2C);
    cyc();
    chk("cp_pre_pcF", pcF, 32'h30);
    cannot_predict = 1; d_is_jump = 1; d_target = 32'h80;
    #1;
    chk("cp_predict", {31'b0, predict_takenD}, 32'd0);
    cyc();
    chk("cp_pcF", pcF, 32'h34);
    zero_inputs();

    // Asynchronous reset mid-cycle, then the trained entry reads weak again.
    redirect(32'h44);
    chk("arst_pre_pcF", pcF, 32'h44);
    #2;
    rst_n = 0;
    #1;
    chk("arst_pcF", pcF, 32'h0);
    chk("arst_validD", {31'b0, validD}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    redirect(32'h20);
    cyc();
    d_is_branch = 1; d_target = 32'h40;
    #1;
    chk("arst_bht_predict", {31'b0, predict_takenD}, 32'd0);
    zero_inputs();

    // PC wraps at the top of the address space.
    redirect(32'hFFFF_FFFC);
    chk("wrap_pre_pcF", pcF, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_pcF", pcF, 32'h0);

    // Random traffic against the model; addresses kept low so the table aliases.
    for (int n = 0; n < 3000; n++) begin
      stall          = ($urandom % 8) == 0;
      cannot_predict = ($urandom % 6) == 0;
      d_is_jump      = ($urandom % 10) == 0;
      d_is_branch    = ($urandom % 3) == 0;
      d_target       = (($urandom % 50) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_01FF);
      e_valid        = ($urandom % 3) == 0;
      e_pc           = (($urandom % 2) == 1) ? m_pcd : ($urandom & 32'h0000_01FF);
      e_taken        = ($urandom % 3) != 0;
      e_mispredict   = ($urandom % 12) == 0;
      e_correct_pc   = $urandom & 32'h0000_03FF;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_predict_unit.md
Name: fetch_predict_unit

Overview:
- Fetch-side PC sequencer with a 2-bit branch history table (BHT) for the 5-stage RV32I pipeline.
- Owns the F-stage PC register and the F/D PC/valid register.
- Redirects fetch on D-stage predicted-taken control transfers.
- Consumes the decode forwarding unit's stall and cannot_predict flags and the E-stage branch resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IDX_BITS, 6, BHT index width; BHT has 2**IDX_BITS entries indexed by pc[IDX_BITS+1:2]

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  D-stage data hazard; hold F and D
cannot_predict  input  1  D-stage target not computable this cycle
d_is_branch  input  1  instruction in D is a conditional branch
d_is_jump  input  1  instruction in D is jal or jalr
d_target  input  32  D-stage computed branch/jump target
e_valid  input  1  E-stage holds a real conditional branch being resolved
e_pc  input  32  PC of the E-stage branch
e_taken  input  1  actual branch outcome in E
e_mispredict  input  1  E-stage redirect required (any control instruction)
e_correct_pc  input  32  correct next PC on mispredict
pcF  output  32  instruction memory fetch address
pcD  output  32  PC of instruction in D
validD  output  1  instruction in D is on the correct path
predict_takenD  output  1  D-stage prediction, carried down the pipe to E

Behaviour:
- Reset (async, rst_n=0):
  - pcF=RESET_PC, pcD=0, validD=0.
  - Every BHT entry = 2'b01 (weakly not-taken).
  - predict_takenD is combinational and reads 0 while validD=0.
- BHT read:
  - Combinational, index pcD[IDX_BITS+1:2].
  - bht_taken = counter[1].
- predict_takenD = validD & ~cannot_predict & (d_is_jump | (d_is_branch & bht_taken)).
- Next-state priority, highest first:
  1. e_mispredict=1: pcF<=e_correct_pc; validD<=0; pcD<=don't-care. Overrides stall, because the D instruction is wrong-path.
  2. stall=1: pcF, pcD, validD hold.
  3. predict_takenD=1: pcF<=d_target; validD<=0, squashing the fall-through fetch; pcD<=pcF.
  4. Otherwise: pcF<=pcF+4, wrapping modulo 2^32; pcD<=pcF; validD<=1.
- cannot_predict=1 forces a not-taken prediction (sequential fetch). E later corrects through e_mispredict.
- One-cycle bubble per predicted-taken transfer. E mispredict costs two bubbles, since D is squashed and F is refetched.
- BHT update:
  - When e_valid=1, counter[e_pc[IDX_BITS+1:2]] saturates up if e_taken, down if not.
  - Saturates at 2'b11 and 2'b00.
  - The update is independent of stall and e_mispredict.
  - Jumps never update the BHT; the driver holds e_valid=0 for them.
- Same-cycle read/write of the same index: the D read returns the pre-update value. No write-through bypass.
- d_target bit 0 is ignored; pcF[1:0] is always 2'b00 (target forced word-aligned). e_correct_pc is also taken with [1:0] forced to 0.
- Reset asserted mid-operation returns all state to reset values immediately, independent of clk.
- First cycle after reset release: fetch at RESET_PC; validD becomes 1 on the following edge unless stall or redirect.

Test Plan:
- Reset then 4 free-running cycles, all inputs 0 -> pcF 0x0,0x4,0x8,0xC; validD 0,1,1,1; pcD lags pcF by one cycle.
- At pcD=0x8, d_is_jump=1, d_target=0x100 -> next cycle pcF=0x100, validD=0; following cycle pcD=0x100, validD=1.
- Branch at pcD=0x20, BHT reset state (01) -> predict_takenD=0. Three E updates with e_pc=0x20, e_taken=1 -> counter 11. Next D visit of 0x20 with d_target=0x40 -> pcF=0x40. A fourth taken update keeps the counter at 11.
- stall=1 for 2 cycles at pcF=0x14 -> pcF, pcD, validD frozen. stall=1 together with e_mispredict=1, e_correct_pc=0x200 -> pcF=0x200, validD=0.
- cannot_predict=1 with d_is_jump=1, d_target=0x80 at pcF=0x30 -> predict_takenD=0, pcF=0x34.
- Assert rst_n=0 between clock edges while pcF=0x44 -> pcF=RESET_PC and validD=0 immediately. BHT entries previously trained to 11 read 01 after reset.
- pcF=0xFFFF_FFFC sequential -> next pcF=0x0000_0000.
